// File: rtl/norm_result_serializer.sv
// Output stage for the four-lane normalizer: buffers complete result vectors
// and streams them out one component per cycle over valid/ready.
module norm_result_serializer #(
  parameter  int DATAWIDTH  = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int W          = 2*DATAWIDTH+2,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid_A,
  input  logic          i_valid_B,
  input  logic          i_valid_C,
  input  logic          i_valid_D,
  input  logic [W-1:0]  in_A,
  input  logic [W-1:0]  in_B,
  input  logic [W-1:0]  in_C,
  input  logic [W-1:0]  in_D,
  input  logic          o_ready,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [1:0]    o_index,
  output logic          o_last,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic          valid_mismatch
);

  // Entry lane 0 holds A, lane 3 holds D.
  logic [3:0][W-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [1:0]    idx_q,    idx_d;
  logic          overflow_q, overflow_d;
  logic          mismatch_q, mismatch_d;

  logic all_v, any_v, full, xfer, pop, push;

  always_comb begin
    all_v = i_valid_A & i_valid_B & i_valid_C & i_valid_D;
    any_v = i_valid_A | i_valid_B | i_valid_C | i_valid_D;
    full  = (count_q == CW'(FIFO_DEPTH));
    xfer  = (count_q != '0) && o_ready;
    pop   = xfer && (idx_q == 2'd3);
    // A full FIFO still takes the push when the head leaves on the same edge.
    push  = all_v && (!full || pop);

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    idx_d      = xfer ? idx_q + 2'd1    : idx_q;
    count_d    = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
    overflow_d = overflow_q | (all_v & full & ~pop);
    mismatch_d = mismatch_q | (any_v & ~all_v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Storage is left unreset; o_data is gated while empty instead.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {in_D, in_C, in_B, in_A};
  end

  assign o_valid        = (count_q != '0);
  assign o_data         = o_valid ? mem_q[rd_ptr_q][idx_q] : '0;
  assign o_index        = idx_q;
  assign o_last         = (idx_q == 2'd3);
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  assign valid_mismatch = mismatch_q;

endmodule

// File: tb/tb_norm_result_serializer.sv
// Randomized and directed bench for norm_result_serializer against a
// queue-based reference model of the vector FIFO and component stream.
module tb_norm_result_serializer;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int W     = 2*DW+2;
  localparam int CW    = $clog2(DEPTH)+1;

  logic          clk, rst;
  logic          i_valid_A, i_valid_B, i_valid_C, i_valid_D;
  logic [W-1:0]  in_A, in_B, in_C, in_D;
  logic          o_ready, o_valid, o_last, overflow, valid_mismatch;
  logic [W-1:0]  o_data;
  logic [1:0]    o_index;
  logic [CW-1:0] fifo_count;

  norm_result_serializer #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_valid_A(i_valid_A), .i_valid_B(i_valid_B),
    .i_valid_C(i_valid_C), .i_valid_D(i_valid_D),
    .in_A(in_A), .in_B(in_B), .in_C(in_C), .in_D(in_D),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .o_index(o_index), .o_last(o_last), .fifo_count(fifo_count),
    .overflow(overflow), .valid_mismatch(valid_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of whole vectors {D,C,B,A}, beat position, flags.
  logic [4*W-1:0] mq[$];
  int             midx;
  bit             movf, mmm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4*W-1:0] h;
    logic [W-1:0]   ed;
    ed = '0;
    if (mq.size() != 0) begin
      h  = mq[0];
      ed = h[midx*W +: W];
    end
    chk("o_valid", 32'(o_valid), 32'(mq.size() != 0));
    chk("o_data",  32'(o_data),  32'(ed));
    chk("o_index", 32'(o_index), 32'(midx));
    chk("o_last",  32'(o_last),  32'(midx == 3));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("valid_mismatch", 32'(valid_mismatch), 32'(mmm));
  endtask

  // Check current state, apply inputs for the next edge, advance the model.
  task automatic step(input logic [3:0] v, input logic [W-1:0] a, b, c, d, input logic rdy);
    bit pop, full;
    @(negedge clk);
    check_all();
    {i_valid_D, i_valid_C, i_valid_B, i_valid_A} = v;
    in_A = a; in_B = b; in_C = c; in_D = d;
    o_ready = rdy;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy && (midx == 3);
    if ((mq.size() != 0) && rdy) midx = (midx + 1) % 4;
    if (pop) void'(mq.pop_front());
    if (v == 4'hF) begin
      if (full && !pop) movf = 1'b1;
      else mq.push_back({d, c, b, a});
    end else if (v != 4'h0) begin
      mmm = 1'b1;
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(4'h0, '0, '0, '0, '0, rdy);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_index"}, 32'(o_index), 32'd0);
    chk({tag, "_last"},  32'(o_last),  32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
    chk({tag, "_mm"},    32'(valid_mismatch), 32'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic reset_between_edges();
    @(negedge clk);
    check_all();
    {i_valid_D, i_valid_C, i_valid_B, i_valid_A} = 4'h0;
    o_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    #1 rst = 1'b0;
    mq.delete();
    midx = 0; movf = 1'b0; mmm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; o_ready = 1'b0;
    {i_valid_D, i_valid_C, i_valid_B, i_valid_A} = 4'h0;
    in_A = '0; in_B = '0; in_C = '0; in_D = '0;
    midx = 0; movf = 1'b0; mmm = 1'b0;
    #12 check_reset_vals("por");
    @(negedge clk) rst = 1'b0;

    // Single vector, ready high.
    step(4'hF, 18'h0B504, 18'h0B504, 18'h0, 18'h0, 1'b1);
    idle(1'b1, 6);

    // Backpressure at index 1 for five cycles.
    step(4'hF, 18'h00111, 18'h00222, 18'h00333, 18'h00444, 1'b0);
    idle(1'b1, 1);
    idle(1'b0, 5);
    idle(1'b1, 5);

    // Overflow: five pushes into a depth-4 FIFO with no drain.
    for (int k = 1; k <= 5; k++)
      step(4'hF, W'(k), W'(k + 16), W'(k + 32), W'(k + 48), 1'b0);
    idle(1'b0, 1);
    chk("ovf_flag",  32'(overflow),   32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    idle(1'b1, 18);

    // Reset mid-emission at index 2 with two vectors queued.
    step(4'hF, 18'h0AAAA, 18'h0BBBB, 18'h0CCCC, 18'h0DDDD, 1'b0);
    step(4'hF, 18'h1AAAA, 18'h1BBBB, 18'h1CCCC, 18'h1DDDD, 1'b1);
    idle(1'b1, 1);
    reset_between_edges();
    step(4'hF, 18'h3F00F, 18'h00F0F, 18'h10101, 18'h2FFFF, 1'b1);
    idle(1'b1, 5);

    // Full FIFO with a pop on the same edge as a fifth push.
    for (int k = 0; k < 4; k++)
      step(4'hF, W'(k + 100), W'(k + 200), W'(k + 300), W'(k + 400), 1'b0);
    idle(1'b1, 3);
    step(4'hF, 18'h3ABCD, 18'h3BCDE, 18'h3CDEF, 18'h3DEF0, 1'b1);
    idle(1'b0, 1);
    chk("fullpop_ovf",   32'(overflow),   32'd0);
    chk("fullpop_count", 32'(fifo_count), 32'd4);
    idle(1'b1, 18);

    // Lane-valid skew: A..C valid, D not.
    step(4'h7, 18'h1, 18'h2, 18'h3, 18'h4, 1'b1);
    idle(1'b1, 1);
    chk("skew_mm",    32'(valid_mismatch), 32'd1);
    chk("skew_count", 32'(fifo_count),     32'd0);
    chk("skew_valid", 32'(o_valid),        32'd0);

    // Randomized traffic.
    reset_between_edges();
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [3:0] v;
      r = int'($urandom_range(0, 99));
      if (r < 28)      v = 4'hF;
      else if (r < 31) v = 4'($urandom_range(1, 14));
      else             v = 4'h0;
      step(v, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
           1'($urandom_range(0, 99) < 75));
    end
    idle(1'b1, 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
